// File: rtl/time_of_day_counter.sv
// Time-of-day counter: prescaled one-second tick, 24-hour binary time, BCD display in 24h or 12h format.
// Loads are range-checked; tick, day-wrap and load-error strobes are registered one-cycle pulses.
module time_of_day_counter #(
  parameter int unsigned TICK_DIV = 100000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       mode_12h,
  input  logic       load,
  input  logic [4:0] load_hours,
  input  logic [5:0] load_minutes,
  input  logic [5:0] load_seconds,
  output logic [3:0] sec_units,
  output logic [2:0] sec_tens,
  output logic [3:0] min_units,
  output logic [2:0] min_tens,
  output logic [3:0] hour_units,
  output logic [1:0] hour_tens,
  output logic       pm,
  output logic       sec_tick,
  output logic       day_wrap,
  output logic       load_err
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  // Split 0..59 into {tens[2:0], units[3:0]}.
  function automatic logic [6:0] bcd_split(input logic [5:0] v);
    logic [2:0] t;
    logic [5:0] base;
    if (v >= 6'd50) begin
      t = 3'd5; base = 6'd50;
    end else if (v >= 6'd40) begin
      t = 3'd4; base = 6'd40;
    end else if (v >= 6'd30) begin
      t = 3'd3; base = 6'd30;
    end else if (v >= 6'd20) begin
      t = 3'd2; base = 6'd20;
    end else if (v >= 6'd10) begin
      t = 3'd1; base = 6'd10;
    end else begin
      t = 3'd0; base = 6'd0;
    end
    return {t, 4'(v - base)};
  endfunction

  // Split 0..23 into {tens[1:0], units[3:0]}.
  function automatic logic [5:0] hour_split(input logic [4:0] h);
    logic [1:0] t;
    logic [4:0] base;
    if (h >= 5'd20) begin
      t = 2'd2; base = 5'd20;
    end else if (h >= 5'd10) begin
      t = 2'd1; base = 5'd10;
    end else begin
      t = 2'd0; base = 5'd0;
    end
    return {t, 4'(h - base)};
  endfunction

  logic [PW-1:0] presc_q, presc_d;
  logic [4:0]    hour_q, hour_d;
  logic [5:0]    min_q, min_d;
  logic [5:0]    sec_q, sec_d;
  logic          sec_tick_q, sec_tick_d;
  logic          day_wrap_q, day_wrap_d;
  logic          load_err_q, load_err_d;

  logic          tick_s;
  logic          load_ok_s;
  logic [4:0]    disp_hour_s;

  assign tick_s    = enable && (presc_q == PRESC_LAST);
  assign load_ok_s = load && (load_hours <= 5'd23) && (load_minutes <= 6'd59)
                     && (load_seconds <= 6'd59);

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q    <= '0;
      hour_q     <= 5'd0;
      min_q      <= 6'd0;
      sec_q      <= 6'd0;
      sec_tick_q <= 1'b0;
      day_wrap_q <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      hour_q     <= hour_d;
      min_q      <= min_d;
      sec_q      <= sec_d;
      sec_tick_q <= sec_tick_d;
      day_wrap_q <= day_wrap_d;
      load_err_q <= load_err_d;
    end
  end

  // A valid load wins over the tick; a rejected load lets the tick proceed.
  always_comb begin
    presc_d    = presc_q;
    hour_d     = hour_q;
    min_d      = min_q;
    sec_d      = sec_q;
    sec_tick_d = 1'b0;
    day_wrap_d = 1'b0;
    load_err_d = load && !load_ok_s;
    if (load_ok_s) begin
      presc_d = '0;
      hour_d  = load_hours;
      min_d   = load_minutes;
      sec_d   = load_seconds;
    end else begin
      if (enable) begin
        presc_d = tick_s ? '0 : presc_q + PW'(1);
      end else begin
        presc_d = presc_q;
      end
      if (tick_s) begin
        sec_tick_d = 1'b1;
        if (sec_q == 6'd59) begin
          sec_d = 6'd0;
          if (min_q == 6'd59) begin
            min_d = 6'd0;
            if (hour_q == 5'd23) begin
              hour_d     = 5'd0;
              day_wrap_d = 1'b1;
            end else begin
              hour_d = hour_q + 5'd1;
            end
          end else begin
            min_d = min_q + 6'd1;
          end
        end else begin
          sec_d = sec_q + 6'd1;
        end
      end else begin
        sec_tick_d = 1'b0;
      end
    end
  end

  // 12-hour view maps 0 to 12 and 13..23 down by 12; pm follows the internal hour.
  always_comb begin
    disp_hour_s = hour_q;
    if (mode_12h) begin
      if (hour_q == 5'd0) begin
        disp_hour_s = 5'd12;
      end else if (hour_q > 5'd12) begin
        disp_hour_s = hour_q - 5'd12;
      end else begin
        disp_hour_s = hour_q;
      end
    end else begin
      disp_hour_s = hour_q;
    end
  end

  assign {sec_tens, sec_units}   = bcd_split(sec_q);
  assign {min_tens, min_units}   = bcd_split(min_q);
  assign {hour_tens, hour_units} = hour_split(disp_hour_s);
  assign pm       = (hour_q >= 5'd12);
  assign sec_tick = sec_tick_q;
  assign day_wrap = day_wrap_q;
  assign load_err = load_err_q;

endmodule

// File: tb/tb_time_of_day_counter.sv
// Directed bench for time_of_day_counter with TICK_DIV=4; expected values are hand-derived.
module tb_time_of_day_counter;

  localparam int unsigned TICK_DIV = 4;

  logic       clk = 1'b0;
  logic       reset, enable, mode_12h, load;
  logic [4:0] load_hours;
  logic [5:0] load_minutes, load_seconds;
  logic [3:0] sec_units, min_units, hour_units;
  logic [2:0] sec_tens, min_tens;
  logic [1:0] hour_tens;
  logic       pm, sec_tick, day_wrap, load_err;

  int n_cmp = 0;
  int n_err = 0;

  time_of_day_counter #(.TICK_DIV(TICK_DIV)) dut (
    .clk(clk), .reset(reset), .enable(enable), .mode_12h(mode_12h), .load(load),
    .load_hours(load_hours), .load_minutes(load_minutes), .load_seconds(load_seconds),
    .sec_units(sec_units), .sec_tens(sec_tens), .min_units(min_units), .min_tens(min_tens),
    .hour_units(hour_units), .hour_tens(hour_tens), .pm(pm),
    .sec_tick(sec_tick), .day_wrap(day_wrap), .load_err(load_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input string field, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s.%s observed=%0d expected=%0d", tag, field, obs, exp);
    end
  endtask

  // Checks all six digits against a 24-hour time.
  task automatic check_time(input string tag, input int h, input int m, input int s);
    chk(tag, "hour_tens", hour_tens, h / 10);
    chk(tag, "hour_units", hour_units, h % 10);
    chk(tag, "min_tens", min_tens, m / 10);
    chk(tag, "min_units", min_units, m % 10);
    chk(tag, "sec_tens", sec_tens, s / 10);
    chk(tag, "sec_units", sec_units, s % 10);
  endtask

  task automatic do_load(input int h, input int m, input int s);
    load = 1'b1;
    load_hours = 5'(h);
    load_minutes = 6'(m);
    load_seconds = 6'(s);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; mode_12h = 1'b0; load = 1'b0;
    load_hours = 5'd0; load_minutes = 6'd0; load_seconds = 6'd0;
    step(); step();

    // Reset state, both display modes
    check_time("reset", 0, 0, 0);
    chk("reset", "pm", pm, 0);
    chk("reset", "sec_tick", sec_tick, 0);
    chk("reset", "day_wrap", day_wrap, 0);
    chk("reset", "load_err", load_err, 0);
    mode_12h = 1'b1; #1;
    chk("reset12", "hour_tens", hour_tens, 1);
    chk("reset12", "hour_units", hour_units, 2);
    chk("reset12", "pm", pm, 0);
    mode_12h = 1'b0;

    // Tick cadence and minute carry after 60 ticks
    reset = 1'b0; enable = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      for (int k = 0; k < 3; k++) begin
        step();
        chk("cadence", "sec_tick", sec_tick, 0);
      end
      step();
      chk("cadence", "sec_tick", sec_tick, 1);
      chk("cadence", "sec_units", sec_units, (i % 60) % 10);
      chk("cadence", "sec_tens", sec_tens, (i % 60) / 10);
    end
    check_time("min_carry", 0, 1, 0);
    chk("min_carry", "sec_tick", sec_tick, 1);

    // Day wrap from 23:59:58
    do_load(23, 59, 58);
    step();
    load = 1'b0;
    check_time("load_2359", 23, 59, 58);
    chk("load_2359", "sec_tick", sec_tick, 0);
    for (int k = 0; k < 3; k++) step();
    step();
    check_time("pre_wrap", 23, 59, 59);
    chk("pre_wrap", "sec_tick", sec_tick, 1);
    chk("pre_wrap", "day_wrap", day_wrap, 0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("pre_wrap_gap", "day_wrap", day_wrap, 0);
    end
    step();
    check_time("wrap", 0, 0, 0);
    chk("wrap", "sec_tick", sec_tick, 1);
    chk("wrap", "day_wrap", day_wrap, 1);
    chk("wrap", "pm", pm, 0);
    step();
    chk("wrap_after", "day_wrap", day_wrap, 0);
    chk("wrap_after", "sec_tick", sec_tick, 0);
    for (int k = 0; k < 2; k++) step();
    step();
    check_time("post_wrap", 0, 0, 1);
    chk("post_wrap", "day_wrap", day_wrap, 0);

    // Rejected loads mid-count, back to back; cadence must hold
    step();
    do_load(24, 0, 0);
    step();
    chk("bad_hour", "load_err", load_err, 1);
    check_time("bad_hour", 0, 0, 1);
    do_load(12, 60, 0);
    step();
    chk("bad_min", "load_err", load_err, 1);
    check_time("bad_min", 0, 0, 1);
    do_load(12, 0, 60);
    step();
    chk("bad_sec", "load_err", load_err, 1);
    chk("bad_sec", "sec_tick", sec_tick, 1);
    check_time("bad_sec", 0, 0, 2);
    load = 1'b0;
    step();
    chk("bad_done", "load_err", load_err, 0);
    chk("bad_done", "sec_tick", sec_tick, 0);

    // 12-hour display
    mode_12h = 1'b1;
    do_load(13, 5, 0);
    step();
    chk("h13", "hour_tens", hour_tens, 0);
    chk("h13", "hour_units", hour_units, 1);
    chk("h13", "pm", pm, 1);
    chk("h13", "min_units", min_units, 5);
    chk("h13", "load_err", load_err, 0);
    mode_12h = 1'b0; #1;
    chk("h13_24", "hour_tens", hour_tens, 1);
    chk("h13_24", "hour_units", hour_units, 3);
    mode_12h = 1'b1;
    do_load(12, 0, 0);
    step();
    chk("h12", "hour_tens", hour_tens, 1);
    chk("h12", "hour_units", hour_units, 2);
    chk("h12", "pm", pm, 1);
    do_load(0, 30, 0);
    step();
    load = 1'b0;
    chk("h00", "hour_tens", hour_tens, 1);
    chk("h00", "hour_units", hour_units, 2);
    chk("h00", "pm", pm, 0);
    chk("h00", "min_tens", min_tens, 3);
    mode_12h = 1'b0;

    // Valid load colliding with a tick, then enable low for 10 cycles
    for (int k = 0; k < 3; k++) step();
    do_load(10, 20, 30);
    step();
    load = 1'b0;
    enable = 1'b0;
    check_time("load_on_tick", 10, 20, 30);
    chk("load_on_tick", "sec_tick", sec_tick, 0);
    for (int k = 0; k < 10; k++) begin
      step();
      chk("hold", "sec_tick", sec_tick, 0);
      chk("hold", "sec_units", sec_units, 0);
    end
    enable = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("resume", "sec_tick", sec_tick, 0);
    end
    step();
    chk("resume_tick", "sec_tick", sec_tick, 1);
    check_time("resume_tick", 10, 20, 31);

    // Reset overrides a simultaneous valid load
    reset = 1'b1;
    do_load(5, 6, 7);
    step();
    check_time("reset_over_load", 0, 0, 0);
    chk("reset_over_load", "sec_tick", sec_tick, 0);
    reset = 1'b0;
    load = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
